// File: rtl/instr_mem_ctrl_pkg.sv
// instr_mem_pkg: shared widths, fetch filler word and loader FSM states.
package instr_mem_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam logic [31:0] DEF_NOP_WORD = 32'h0;
  typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;
endpackage

// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: program-loader stream and fetch port of the instruction memory.
interface instr_mem_ctrl_if
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SLOT_W = 2
);
  logic              load_start;
  logic [SLOT_W-1:0] load_slot;
  logic [ADDR_W-1:0] load_base;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_err;
  logic              fetch_en;
  logic [SLOT_W-1:0] prog_sel;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] instrucao;
  logic              instr_valid;
  logic              addr_err;
  modport master (
    output load_start, load_slot, load_base, load_valid, load_data, load_last,
    output fetch_en, prog_sel, address,
    input  load_ready, load_done, load_err, instrucao, instr_valid, addr_err
  );
  modport slave (
    input  load_start, load_slot, load_base, load_valid, load_data, load_last,
    input  fetch_en, prog_sel, address,
    output load_ready, load_done, load_err, instrucao, instr_valid, addr_err
  );
endinterface

// File: rtl/instr_mem_ctrl_ram.sv
// instr_ram: single-port synchronous RAM; a write takes the port, otherwise the fetch address reads.
module instr_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] addr;
  assign addr = we_i ? wr_addr_i : rd_addr_i;
  // Read data only updates on a read, so it holds across idle and write cycles.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr] <= wdata_i;
    else if (re_i) rdata_o <= mem_q[addr];
  end
endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: loadable instruction memory with per-slot base/length tables and bounds-checked fetch.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 1024,
  parameter int NUM_PROG = 4,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
  input logic clock,
  input logic reset_n,
  instr_mem_ctrl_if.slave bus
);
  localparam int SLOT_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
  localparam int NSLOT  = 1 << SLOT_W;
  localparam int AW1    = ADDR_W + 1;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d;
  logic [AW1-1:0]    cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              done_q, done_d, err_q, err_d, tab_we;
  logic [ADDR_W-1:0] base_tab_q [NSLOT];
  logic [AW1-1:0]    len_tab_q [NSLOT];
  logic              valid_q, addr_err_q, use_ram_q;
  logic              beat, bad_base, at_end, idle, oob, rd_en;
  logic [AW1-1:0]    phys;
  logic [DATA_W-1:0] rdata;
  assign beat     = state_q == LOAD && bus.load_valid;
  assign bad_base = {1'b0, bus.load_base} >= AW1'(DEPTH);
  assign at_end   = wr_ptr_q == ADDR_W'(DEPTH - 1);
  assign idle     = state_q == IDLE;
  assign phys     = {1'b0, base_tab_q[bus.prog_sel]} + {1'b0, bus.address};
  assign oob      = {1'b0, bus.address} >= len_tab_q[bus.prog_sel] || phys >= AW1'(DEPTH);
  assign rd_en    = bus.fetch_en && idle && !oob;
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    base_d   = base_q;
    err_d    = err_q;
    done_d   = 1'b0;
    tab_we   = 1'b0;
    if (state_q != LOAD && bus.load_start) begin
      state_d  = bad_base ? ERR : LOAD;
      err_d    = bad_base;
      wr_ptr_d = bus.load_base;
      cnt_d    = '0;
      slot_d   = bus.load_slot;
      base_d   = bus.load_base;
    end else if (beat) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      cnt_d    = cnt_q + AW1'(1);
      if (bus.load_last) begin
        tab_we  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end else if (at_end) begin
        state_d = ERR;
        err_d   = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      slot_q     <= '0;
      base_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      addr_err_q <= 1'b0;
      use_ram_q  <= 1'b0;
      for (int i = 0; i < NSLOT; i++) begin
        base_tab_q[i] <= '0;
        len_tab_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      base_q   <= base_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= bus.fetch_en && idle;
      if (tab_we) begin
        base_tab_q[slot_q] <= base_q;
        len_tab_q[slot_q]  <= cnt_q + AW1'(1);
      end
      // With fetch_en low the selection holds, so instrucao keeps its last value.
      if (bus.fetch_en) begin
        addr_err_q <= idle && oob;
        use_ram_q  <= rd_en;
      end
    end
  end
  instr_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk       (clock),
    .we_i      (beat),
    .re_i      (rd_en),
    .wr_addr_i (wr_ptr_q),
    .rd_addr_i (phys[ADDR_W-1:0]),
    .wdata_i   (bus.load_data),
    .rdata_o   (rdata)
  );
  assign bus.load_ready  = state_q == LOAD;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.instrucao   = use_ram_q ? rdata : NOP_WORD;
  assign bus.instr_valid = valid_q;
  assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed load/fetch scenarios with hand-computed expectations.
module tb_instr_mem_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;
  always #5 clock = ~clock;
  instr_mem_ctrl_if #(.DATA_W(32), .ADDR_W(10), .SLOT_W(2)) bus ();
  instr_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .NUM_PROG(4), .NOP_WORD(32'h0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input int slot, input int base);
    bus.load_start = 1'b1;
    bus.load_slot  = 2'(slot);
    bus.load_base  = 10'(base);
    step;
    bus.load_start = 1'b0;
  endtask
  task automatic beat(input logic [31:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    step;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask
  task automatic fetch(input int sel, input int a);
    bus.fetch_en = 1'b1;
    bus.prog_sel = 2'(sel);
    bus.address  = 10'(a);
    step;
    bus.fetch_en = 1'b0;
  endtask
  initial begin
    bus.load_start = 0; bus.load_slot = 0; bus.load_base = 0; bus.load_valid = 0;
    bus.load_data = 0; bus.load_last = 0; bus.fetch_en = 0; bus.prog_sel = 0; bus.address = 0;
    step; step;
    chk("rst_ready", bus.load_ready, 0);
    chk("rst_done", bus.load_done, 0);
    chk("rst_err", bus.load_err, 0);
    chk("rst_instr", bus.instrucao, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    reset_n = 1'b1;
    step;
    fetch(0, 0);
    chk("empty_addr_err", bus.addr_err, 1);
    chk("empty_valid", bus.instr_valid, 1);
    chk("empty_instr", bus.instrucao, 0);
    // valid alongside load_start must not be taken as a beat
    bus.load_valid = 1'b1;
    bus.load_data  = 32'hDEAD_BEEF;
    start(1, 15);
    chk("ld1_ready", bus.load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      beat(32'h1111_0000 + 32'(i), i == 3);
      chk("ld1_done", bus.load_done, (i == 3) ? 1 : 0);
    end
    step;
    chk("ld1_done_drop", bus.load_done, 0);
    chk("ld1_ready_drop", bus.load_ready, 0);
    bus.fetch_en = 1'b1;
    bus.prog_sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      bus.address = 10'(i);
      step;
      chk("f1_instr", bus.instrucao, 32'h1111_0000 + 32'(i));
      chk("f1_valid", bus.instr_valid, 1);
      chk("f1_addr_err", bus.addr_err, 0);
    end
    bus.fetch_en = 1'b0;
    step;
    chk("hold_valid", bus.instr_valid, 0);
    chk("hold_instr", bus.instrucao, 32'h1111_0003);
    fetch(1, 4);
    chk("f1_len_err", bus.addr_err, 1);
    chk("f1_len_instr", bus.instrucao, 0);
    bus.fetch_en = 1'b1;
    bus.prog_sel = 2'd1;
    bus.address  = 10'd2;
    start(2, 100);
    chk("st_first", bus.instrucao, 32'h1111_0002);
    beat(32'h2222_0000, 1'b0);
    chk("st_valid", bus.instr_valid, 0);
    chk("st_instr", bus.instrucao, 0);
    chk("st_addr_err", bus.addr_err, 0);
    beat(32'h2222_0001, 1'b1);
    chk("st_valid2", bus.instr_valid, 0);
    chk("st_done", bus.load_done, 1);
    bus.prog_sel = 2'd2;
    bus.address  = 10'd1;
    step;
    chk("resume_valid", bus.instr_valid, 1);
    chk("resume_instr", bus.instrucao, 32'h2222_0001);
    chk("resume_addr_err", bus.addr_err, 0);
    bus.fetch_en = 1'b0;
    start(3, 1022);
    chk("ov_ready", bus.load_ready, 1);
    beat(32'h3333_0000, 1'b0);
    chk("ov_err_early", bus.load_err, 0);
    beat(32'h3333_0001, 1'b0);
    chk("ov_err", bus.load_err, 1);
    chk("ov_ready_low", bus.load_ready, 0);
    beat(32'h3333_0002, 1'b0);
    chk("ov_err_sticky", bus.load_err, 1);
    chk("ov_no_done", bus.load_done, 0);
    start(3, 200);
    chk("ov_clear", bus.load_err, 0);
    chk("ov_reload_ready", bus.load_ready, 1);
    beat(32'h4444_0000, 1'b1);
    chk("ov_reload_done", bus.load_done, 1);
    fetch(3, 0);
    chk("s3_instr", bus.instrucao, 32'h4444_0000);
    fetch(3, 1);
    chk("s3_len", bus.addr_err, 1);
    fetch(1, 3);
    chk("s1_kept", bus.instrucao, 32'h1111_0003);
    start(1, 300);
    beat(32'h5555_0000, 1'b0);
    beat(32'h5555_0001, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", bus.load_ready, 0);
    step;
    reset_n = 1'b1;
    step;
    chk("arst_done", bus.load_done, 0);
    chk("arst_err", bus.load_err, 0);
    chk("arst_instr", bus.instrucao, 0);
    chk("arst_valid", bus.instr_valid, 0);
    fetch(1, 0);
    chk("arst_len", bus.addr_err, 1);
    start(0, 50);
    beat(32'h6666_0000, 1'b0);
    beat(32'h6666_0001, 1'b1);
    fetch(0, 1);
    chk("s0_old", bus.instrucao, 32'h6666_0001);
    start(0, 500);
    beat(32'h7777_0000, 1'b0);
    start(1, 700);
    chk("ign_start", bus.load_ready, 1);
    beat(32'h7777_0001, 1'b0);
    beat(32'h7777_0002, 1'b1);
    chk("s0_done", bus.load_done, 1);
    for (int i = 0; i < 3; i++) begin
      fetch(0, i);
      chk("s0_new", bus.instrucao, 32'h7777_0000 + 32'(i));
    end
    fetch(0, 3);
    chk("s0_len", bus.addr_err, 1);
    fetch(1, 0);
    chk("ign_slot1", bus.addr_err, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory with a run-time program loader, replacing the fixed power-on image. It feeds the fetch stage of the MIPS datapath. Software or a host streams programs into the memory over a valid/ready port, one slot at a time. Fetch addresses are slot-relative and bounds-checked against the length of the loaded program.

## Interface
Parameters:
- DATA_W, 32, instruction width
- ADDR_W, 10, address width (fetch and load)
- DEPTH, 1024, memory words; must be ≤ 2^ADDR_W
- NUM_PROG, 4, program slots; SLOT_W = $clog2(NUM_PROG)
- NOP_WORD, 32'h0, word driven on invalid or stalled fetch

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse; opens a load session (honoured only in IDLE)
- load_slot  in  SLOT_W  slot being loaded, sampled with load_start
- load_base  in  ADDR_W  physical start address, sampled with load_start
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  instruction word
- load_last  in  1  qualifies the final word of the session
- load_ready  out  1  high in LOAD state only
- load_done  out  1  one-cycle pulse on successful session end
- load_err  out  1  sticky overflow flag; cleared by the next accepted load_start
- fetch_en  in  1  fetch request
- prog_sel  in  SLOT_W  active program slot
- address  in  ADDR_W  slot-relative instruction index
- instrucao  out  DATA_W  fetched instruction (registered)
- instr_valid  out  1  instrucao is a real fetch result
- addr_err  out  1  fetch was out of bounds

## Operation
- FSM states: IDLE, LOAD, ERR.
- IDLE → LOAD on load_start. On entry: wr_ptr ← load_base, cnt ← 0, latch the slot, clear load_err.
- In LOAD, each beat (load_valid && load_ready) does: RAM[wr_ptr] ← load_data, wr_ptr+1, cnt+1.
- Beat with load_last:
  - base_tab[slot] ← latched base, len_tab[slot] ← cnt+1.
  - load_done is pulsed and the FSM returns to IDLE.
- Beat written at wr_ptr == DEPTH-1 without load_last → ERR. In ERR: load_ready=0, load_err=1, and the slot table is not updated.
- ERR → LOAD on load_start; otherwise ERR holds.
- load_start in LOAD is ignored.
- If load_base ≥ DEPTH at load_start → ERR immediately; nothing is written.
- Fetch: phys = base_tab[prog_sel] + address, computed at ADDR_W+1 bits with no wrap.
  - Invalid if address ≥ len_tab[prog_sel], or phys ≥ DEPTH. Then instrucao=NOP_WORD, addr_err=1, instr_valid=1.
  - Otherwise instrucao=RAM[phys], addr_err=0, instr_valid=1.
- Fetch while state ≠ IDLE is stalled: instr_valid=0, instrucao=NOP_WORD, addr_err=0. The request is dropped, not queued.
- fetch_en=0: instr_valid=0. instrucao holds its last value.
- Unloaded slot (len 0): every fetch gives addr_err.
- A slot may be reloaded. Overlapping physical regions are allowed; the last write wins.

## Timing
- Reset (async assert, sync release): state=IDLE, load_ready=0, load_done=0, load_err=0, instrucao=NOP_WORD, instr_valid=0, addr_err=0, and all base_tab and len_tab entries = 0.
- RAM contents are not reset and survive reset. Because every len_tab entry is 0, all post-reset fetches give addr_err.
- Reset mid-load aborts the session. The partial data stays in RAM but no slot table entry is updated.
- load_ready rises the cycle after load_start is sampled. A load_valid in the same cycle as load_start is not accepted.
- load_done pulses the cycle after the load_last beat. The new table entry and data are visible to a fetch issued in that same cycle.
- Fetch latency is 1 cycle: request at edge N, result valid after edge N+1.
- Back-to-back fetches give one result per cycle.
- Read-during-write cannot happen, because fetch stalls outside IDLE.

## Structure
- Package instr_mem_pkg holds DATA_W/ADDR_W defaults, the NOP_WORD constant, and the FSM state enum {IDLE, LOAD, ERR}.
- Sub-module instr_ram: single-port synchronous RAM, DEPTH×DATA_W, write-enable plus registered read, with the address mux selecting between the loader and fetch.
- The top level holds the FSM, pointers, slot tables, bounds check and output mux.

## Test plan
- Reset, then fetch slot 0, address 0 → addr_err=1, instr_valid=1, instrucao=0.
- Load slot 1 at base 15 with 4 words (last on the 4th) → load_done pulses once. Fetch slot 1 addresses 0..3 → the 4 words, 1-cycle latency. Address 4 → addr_err.
- Load base DEPTH-2 with 3 words and no early last → ERR and load_err=1 after the 2nd beat. The old slot table is unchanged. A new load_start clears load_err.
- Fetch_en held during a load → instr_valid=0 every cycle. Normal fetch resumes on the load_done cycle.
- Assert reset_n=0 mid-load after 2 beats, then release → all outputs at reset values and len_tab[slot]=0.
- Reload slot 0 with different data and base; load_start during LOAD is ignored → fetch returns the new data at the new base.
